// File: rtl/generator_pwm_motoare.sv
// generator_pwm_motoare: dual-channel H-bridge drive stage.
// Owns a shared 000-999 BCD PWM counter, latches the BCD duty factors once per
// period, and runs one direction FSM per channel. A direction reversal passes
// through a dead-time during which both IN lines are held at 00.
//
// Handshake: there is none. Every input is level-sampled on each clk edge.
// The direction codes are asynchronous to clk and are resynchronized here.
// Enable and the duty factors are assumed synchronous to clk.
module generator_pwm_motoare #(
    parameter int PRESCALE  = 50,
    parameter int DEAD_TIME = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  directie_driverA,
    input  logic [1:0]  directie_driverB,
    input  logic [11:0] factor_dc_driverA,
    input  logic [11:0] factor_dc_driverB,
    output logic [1:0]  in_driverA,
    output logic [1:0]  in_driverB,
    output logic        pwm_enA,
    output logic        pwm_enB,
    output logic [11:0] numarator,
    output logic        sfarsit_perioada
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_TIME - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } stare_t;

    // A BCD digit above 9 is treated as 9, so 0xFFF behaves as 999.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [11:0] clamp_bcd(input logic [11:0] v);
        return {clamp_digit(v[11:8]), clamp_digit(v[7:4]), clamp_digit(v[3:0])};
    endfunction

    logic [PW-1:0] presc;
    logic          tick;
    logic          wrap;
    logic [11:0]   duty_lat [2];
    logic [1:0]    pwm_raw;
    logic [1:0]    dir_raw  [2];
    logic [1:0]    dir_s1   [2];
    logic [1:0]    dir_s    [2];
    logic [1:0]    dir_ok;
    stare_t        stare    [2];
    logic [1:0]    dir_act  [2];
    logic [1:0]    dir_tgt  [2];
    logic [DW-1:0] dead_cnt [2];
    logic [1:0]    in_q     [2];
    logic [1:0]    pwm_q;

    assign tick = (presc == PRE_MAX);
    assign wrap = tick && (numarator == 12'h999);

    assign dir_raw[0] = directie_driverA;
    assign dir_raw[1] = directie_driverB;

    // Only 10 and 01 are drive codes; 00 and 11 both mean stop.
    assign dir_ok[0] = dir_s[0][1] ^ dir_s[0][0];
    assign dir_ok[1] = dir_s[1][1] ^ dir_s[1][0];

    // Plain binary compare is correct because latched duties are clamped BCD.
    assign pwm_raw[0] = (numarator < duty_lat[0]);
    assign pwm_raw[1] = (numarator < duty_lat[1]);

    // Prescaler: one counter step every PRESCALE clocks, independent of enable.
    always_ff @(posedge clk) begin
        if (!rst_n)    presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // Shared BCD counter 000..999 with a one-clock pulse on the wrap to 000.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            numarator        <= 12'h000;
            sfarsit_perioada <= 1'b0;
        end else begin
            sfarsit_perioada <= wrap;
            if (tick) begin
                if (numarator[3:0] == 4'd9) begin
                    numarator[3:0] <= 4'd0;
                    if (numarator[7:4] == 4'd9) begin
                        numarator[7:4]  <= 4'd0;
                        numarator[11:8] <= (numarator[11:8] == 4'd9) ? 4'd0
                                                                     : numarator[11:8] + 4'd1;
                    end else begin
                        numarator[7:4] <= numarator[7:4] + 4'd1;
                    end
                end else begin
                    numarator[3:0] <= numarator[3:0] + 4'd1;
                end
            end
        end
    end

    // Duty shadow registers load on the wrap edge, so the value present at that
    // edge governs the whole period starting at 000; mid-period writes wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_lat[0] <= 12'h000;
            duty_lat[1] <= 12'h000;
        end else if (wrap) begin
            duty_lat[0] <= clamp_bcd(factor_dc_driverA);
            duty_lat[1] <= clamp_bcd(factor_dc_driverB);
        end
    end

    // Two-flop synchronizer per channel for the sensor-derived direction codes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                dir_s1[c] <= 2'b00;
                dir_s[c]  <= 2'b00;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                dir_s1[c] <= dir_raw[c];
                dir_s[c]  <= dir_s1[c];
            end
        end
    end

    // Per-channel direction FSM; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                stare[c]    <= ST_STOP;
                dir_act[c]  <= 2'b00;
                dir_tgt[c]  <= 2'b00;
                dead_cnt[c] <= '0;
                in_q[c]     <= 2'b00;
                pwm_q[c]    <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                in_q[c]  <= 2'b00;
                pwm_q[c] <= 1'b0;
                case (stare[c])
                    ST_STOP: begin
                        if (enable && dir_ok[c]) begin
                            stare[c]   <= ST_RUN;
                            dir_act[c] <= dir_s[c];
                            in_q[c]    <= dir_s[c];
                            pwm_q[c]   <= pwm_raw[c];
                        end
                    end
                    ST_RUN: begin
                        if (!enable || !dir_ok[c]) begin
                            stare[c] <= ST_STOP;
                        end else if (dir_s[c] != dir_act[c]) begin
                            stare[c]    <= ST_DEAD;
                            dir_tgt[c]  <= dir_s[c];
                            dead_cnt[c] <= DEAD_LOAD;
                        end else begin
                            in_q[c]  <= dir_act[c];
                            pwm_q[c] <= pwm_raw[c];
                        end
                    end
                    ST_DEAD: begin
                        if (!enable || !dir_ok[c]) begin
                            stare[c] <= ST_STOP;
                        end else if (dir_s[c] != dir_tgt[c]) begin
                            // Target flipped again: the full dead-time restarts.
                            dir_tgt[c]  <= dir_s[c];
                            dead_cnt[c] <= DEAD_LOAD;
                        end else if (dead_cnt[c] == '0) begin
                            stare[c]   <= ST_RUN;
                            dir_act[c] <= dir_tgt[c];
                            in_q[c]    <= dir_tgt[c];
                            pwm_q[c]   <= pwm_raw[c];
                        end else begin
                            dead_cnt[c] <= dead_cnt[c] - 1'b1;
                        end
                    end
                    default: stare[c] <= ST_STOP;
                endcase
            end
        end
    end

    assign in_driverA = in_q[0];
    assign in_driverB = in_q[1];
    assign pwm_enA    = pwm_q[0];
    assign pwm_enB    = pwm_q[1];

endmodule

// File: tb/tb_generator_pwm_motoare.sv
// Bench for generator_pwm_motoare: counter, duty, reversal, abort, enable/reset.
// The reference model works in decimal steps counted from the reset release.
module tb_generator_pwm_motoare;

    localparam int PRESCALE  = 2;
    localparam int DEAD_TIME = 5;
    localparam int PERIOD    = 1000 * PRESCALE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  dir_a = 2'b00;
    logic [1:0]  dir_b = 2'b00;
    logic [11:0] fa = 12'h000;
    logic [11:0] fb = 12'h000;
    logic [1:0]  in_a, in_b;
    logic        pwm_a, pwm_b;
    logic [11:0] numarator;
    logic        sfarsit;

    int checks = 0;
    int errors = 0;
    int n_edges = 0;
    int duty_m [2];
    logic [1:0] exp_cmp = 2'b00;

    generator_pwm_motoare #(.PRESCALE(PRESCALE), .DEAD_TIME(DEAD_TIME)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .directie_driverA(dir_a), .directie_driverB(dir_b),
        .factor_dc_driverA(fa), .factor_dc_driverB(fb),
        .in_driverA(in_a), .in_driverB(in_b),
        .pwm_enA(pwm_a), .pwm_enB(pwm_b),
        .numarator(numarator), .sfarsit_perioada(sfarsit)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int step_of(input int n);
        return (n / PRESCALE) % 1000;
    endfunction

    function automatic logic [11:0] exp_num(input int n);
        int s;
        s = step_of(n);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic exp_wrap(input int n);
        return (n > 0) && (n % PERIOD == 0);
    endfunction

    function automatic int clamp_dec(input logic [11:0] v);
        int h, t, u;
        h = (v[11:8] > 4'd9) ? 9 : int'(v[11:8]);
        t = (v[7:4]  > 4'd9) ? 9 : int'(v[7:4]);
        u = (v[3:0]  > 4'd9) ? 9 : int'(v[3:0]);
        return h * 100 + t * 10 + u;
    endfunction

    // Advance one edge, update the model, and return 1 time unit after the edge.
    task automatic clk_step();
        @(posedge clk);
        if (!rst_n) begin
            n_edges   = 0;
            duty_m[0] = 0;
            duty_m[1] = 0;
            exp_cmp   = 2'b00;
        end else begin
            n_edges++;
            for (int c = 0; c < 2; c++)
                exp_cmp[c] = (step_of(n_edges - 1) < duty_m[c]);
            if (exp_wrap(n_edges)) begin
                duty_m[0] = clamp_dec(fa);
                duty_m[1] = clamp_dec(fb);
            end
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; dir_a = 2'b00; dir_b = 2'b00; fa = 12'h000; fb = 12'h000;
        repeat (3) clk_step();
        checks++; if (numarator !== 12'h000) begin errors++; $display("FAIL reset_num got %h exp 000", numarator); end
        checks++; if (sfarsit !== 1'b0) begin errors++; $display("FAIL reset_sfarsit got %b exp 0", sfarsit); end
        checks++; if (in_a !== 2'b00) begin errors++; $display("FAIL reset_inA got %b exp 00", in_a); end
        checks++; if (in_b !== 2'b00) begin errors++; $display("FAIL reset_inB got %b exp 00", in_b); end
        checks++; if (pwm_a !== 1'b0) begin errors++; $display("FAIL reset_pwmA got %b exp 0", pwm_a); end
        checks++; if (pwm_b !== 1'b0) begin errors++; $display("FAIL reset_pwmB got %b exp 0", pwm_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        int pulses = 0;
        int last = 0;
        for (int i = 0; i < 2 * PERIOD + 10; i++) begin
            clk_step();
            checks++;
            if (numarator !== exp_num(n_edges)) begin
                errors++; $display("FAIL free_num n=%0d got %h exp %h", n_edges, numarator, exp_num(n_edges));
            end
            checks++;
            if (sfarsit !== exp_wrap(n_edges)) begin
                errors++; $display("FAIL free_sfarsit n=%0d got %b exp %b", n_edges, sfarsit, exp_wrap(n_edges));
            end
            checks++;
            if ({in_a, in_b, pwm_a, pwm_b} !== 6'b0) begin
                errors++; $display("FAIL free_drive n=%0d got %b exp 000000", n_edges, {in_a, in_b, pwm_a, pwm_b});
            end
            if (sfarsit === 1'b1) begin
                pulses++;
                if (last > 0) begin
                    checks++;
                    if (n_edges - last != PERIOD) begin
                        errors++; $display("FAIL free_spacing got %0d exp %0d", n_edges - last, PERIOD);
                    end
                end
                last = n_edges;
            end
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL free_pulses got %0d exp 2", pulses); end
    endtask

    task automatic test_duty();
        logic [11:0] la [7];
        logic [11:0] lb [7];
        int hi_a, hi_b;
        la = '{12'h250, 12'h000, 12'h999, 12'hFFF, 12'h100, 12'h800, 12'h000};
        la[6] = 12'($urandom_range(0, 4095));
        for (int p = 0; p < 7; p++) lb[p] = 12'($urandom_range(0, 4095));
        fa = la[0]; fb = lb[0];
        dir_a = 2'b10; dir_b = 2'b01; enable = 1'b1;
        for (int w = 0; w < PERIOD + 10 && !exp_wrap(n_edges); w++) clk_step();
        checks++;
        if (!exp_wrap(n_edges) || sfarsit !== 1'b1) begin
            errors++; $display("FAIL duty_wrap_sync got %b exp 1", sfarsit);
        end
        for (int p = 0; p < 7; p++) begin
            hi_a = 0; hi_b = 0;
            for (int k = 1; k <= PERIOD; k++) begin
                // k == 1001 is just after numarator reaches 500: mid-period write.
                if (k == PERIOD / 2 + 1 && p < 6) begin fa = la[p + 1]; fb = lb[p + 1]; end
                clk_step();
                if (pwm_a === 1'b1) hi_a++;
                if (pwm_b === 1'b1) hi_b++;
                checks++;
                if (pwm_a !== exp_cmp[0]) begin
                    errors++; $display("FAIL duty_pwmA p=%0d k=%0d got %b exp %b", p, k, pwm_a, exp_cmp[0]);
                end
                checks++;
                if (pwm_b !== exp_cmp[1]) begin
                    errors++; $display("FAIL duty_pwmB p=%0d k=%0d got %b exp %b", p, k, pwm_b, exp_cmp[1]);
                end
                checks++;
                if (in_a !== 2'b10 || in_b !== 2'b01) begin
                    errors++; $display("FAIL duty_in p=%0d k=%0d got %b/%b exp 10/01", p, k, in_a, in_b);
                end
            end
            checks++;
            if (hi_a != clamp_dec(la[p]) * PRESCALE) begin
                errors++; $display("FAIL duty_countA p=%0d got %0d exp %0d", p, hi_a, clamp_dec(la[p]) * PRESCALE);
            end
            checks++;
            if (hi_b != clamp_dec(lb[p]) * PRESCALE) begin
                errors++; $display("FAIL duty_countB p=%0d got %0d exp %0d", p, hi_b, clamp_dec(lb[p]) * PRESCALE);
            end
        end
    endtask

    task automatic test_reversal();
        logic [1:0] ea;
        dir_a = 2'b01;
        for (int i = 0; i < 10; i++) begin
            clk_step();
            ea = (i < 2) ? 2'b10 : (i < 2 + DEAD_TIME) ? 2'b00 : 2'b01;
            checks++;
            if (in_a !== ea) begin errors++; $display("FAIL rev_inA i=%0d got %b exp %b", i, in_a, ea); end
            checks++;
            if (pwm_a !== ((ea != 2'b00) ? exp_cmp[0] : 1'b0)) begin
                errors++; $display("FAIL rev_pwmA i=%0d got %b", i, pwm_a);
            end
            checks++;
            if (in_b !== 2'b01) begin errors++; $display("FAIL rev_inB i=%0d got %b exp 01", i, in_b); end
        end
    endtask

    task automatic test_abort_stop();
        logic [1:0] ea;
        dir_a = 2'b10;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) dir_a = 2'b00;
            clk_step();
            ea = (i < 2) ? 2'b01 : 2'b00;
            checks++;
            if (in_a !== ea) begin errors++; $display("FAIL abort00_inA i=%0d got %b exp %b", i, in_a, ea); end
            checks++;
            if (pwm_a !== ((ea != 2'b00) ? exp_cmp[0] : 1'b0)) begin
                errors++; $display("FAIL abort00_pwmA i=%0d got %b", i, pwm_a);
            end
        end
        // Start from STOP: no dead-time, only the synchronizer latency.
        dir_a = 2'b10;
        for (int i = 0; i < 4; i++) begin
            clk_step();
            ea = (i < 2) ? 2'b00 : 2'b10;
            checks++;
            if (in_a !== ea) begin errors++; $display("FAIL start_inA i=%0d got %b exp %b", i, in_a, ea); end
        end
    endtask

    task automatic test_abort_retarget();
        logic [1:0] ea;
        dir_a = 2'b01;
        for (int i = 0; i < 14; i++) begin
            if (i == 4) dir_a = 2'b10;
            clk_step();
            // Re-detect at i=6 restarts the dead-time: 10 returns at i=6+DEAD_TIME.
            ea = (i < 2) ? 2'b10 : (i < 6 + DEAD_TIME) ? 2'b00 : 2'b10;
            checks++;
            if (in_a !== ea) begin errors++; $display("FAIL retarget_inA i=%0d got %b exp %b", i, in_a, ea); end
            checks++;
            if (pwm_a !== ((ea != 2'b00) ? exp_cmp[0] : 1'b0)) begin
                errors++; $display("FAIL retarget_pwmA i=%0d got %b", i, pwm_a);
            end
        end
    endtask

    task automatic test_code11();
        logic [1:0] ea;
        dir_a = 2'b11;
        for (int i = 0; i < 8; i++) begin
            clk_step();
            ea = (i < 2) ? 2'b10 : 2'b00;
            checks++;
            if (in_a !== ea) begin errors++; $display("FAIL code11_inA i=%0d got %b exp %b", i, in_a, ea); end
        end
        dir_a = 2'b10;
        repeat (3) clk_step();
        checks++;
        if (in_a !== 2'b10) begin errors++; $display("FAIL code11_restart got %b exp 10", in_a); end
    endtask

    task automatic test_enable_reset();
        logic [1:0] ea;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clk_step();
            checks++;
            if ({in_a, in_b, pwm_a, pwm_b} !== 6'b0) begin
                errors++; $display("FAIL en0_drive i=%0d got %b exp 000000", i, {in_a, in_b, pwm_a, pwm_b});
            end
            checks++;
            if (numarator !== exp_num(n_edges)) begin
                errors++; $display("FAIL en0_num i=%0d got %h exp %h", i, numarator, exp_num(n_edges));
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            checks++;
            if (in_a !== 2'b10 || in_b !== 2'b01) begin
                errors++; $display("FAIL en1_in i=%0d got %b/%b exp 10/01", i, in_a, in_b);
            end
            checks++;
            if (pwm_a !== exp_cmp[0] || pwm_b !== exp_cmp[1]) begin
                errors++; $display("FAIL en1_pwm i=%0d got %b%b exp %b%b", i, pwm_a, pwm_b, exp_cmp[0], exp_cmp[1]);
            end
        end
        dir_a = 2'b01;
        repeat (3) clk_step();
        checks++;
        if (in_a !== 2'b00) begin errors++; $display("FAIL rst_pre_dead got %b exp 00", in_a); end
        rst_n = 1'b0;
        clk_step();
        checks++;
        if ({numarator, sfarsit, in_a, in_b, pwm_a, pwm_b} !== 19'b0) begin
            errors++; $display("FAIL rst_dead_outputs got num=%h s=%b in=%b/%b pwm=%b%b exp all 0",
                               numarator, sfarsit, in_a, in_b, pwm_a, pwm_b);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clk_step();
            ea = (i < 2) ? 2'b00 : 2'b01;
            checks++;
            if (in_a !== ea || in_b !== ea) begin
                errors++; $display("FAIL post_rst_in i=%0d got %b/%b exp %b", i, in_a, in_b, ea);
            end
            checks++;
            if (numarator !== exp_num(n_edges)) begin
                errors++; $display("FAIL post_rst_num i=%0d got %h exp %h", i, numarator, exp_num(n_edges));
            end
            checks++;
            if (pwm_a !== ((ea != 2'b00) ? exp_cmp[0] : 1'b0)) begin
                errors++; $display("FAIL post_rst_pwmA i=%0d got %b", i, pwm_a);
            end
        end
    endtask

    // Sequencer and final report
    initial begin
        duty_m[0] = 0;
        duty_m[1] = 0;
        test_reset();
        test_free_run();
        test_duty();
        test_reversal();
        test_abort_stop();
        test_abort_retarget();
        test_code11();
        test_enable_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
